// File: rtl/hex_word_serializer_pkg.sv
// Shared types and constants for the hex word serializer and its nibble converter.
package hex_word_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_HEX,
    SEND_CR,
    SEND_LF
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Uppercase ASCII for one hex digit: '0'..'9' from 0x30, 'A'..'F' from 0x37+10.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/hex_word_serializer_conv.sv
// Registered nibble-to-ASCII converter: one cycle from nibble_i to ascii_o.
module nibble_hex_converter
  import hex_word_serializer_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  logic [7:0] ascii_q;

  // NOTE: pure datapath register, deliberately not reset; its value is only
  // consumed one cycle after a valid nibble has been presented.
  always_ff @(posedge clk) begin
    ascii_q <= nibble_to_ascii(nibble_i);
  end

  assign ascii_o = ascii_q;

endmodule

// File: rtl/hex_word_serializer.sv
// Serializes one binary word into uppercase ASCII hex characters, MS nibble
// first, with an optional CR/LF trailer, over valid/ready handshakes.
module hex_word_serializer
  import hex_word_serializer_pkg::*;
#(
  parameter int DATA_BYTES     = 16,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int W      = 8 * DATA_BYTES;
  localparam int NCHARS = 2 * DATA_BYTES;
  localparam int CW     = $clog2(NCHARS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHARS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      conv_char;

  // The converter continuously samples the top nibble; it only changes on a
  // handshake, so a stalled SEND_HEX keeps presenting the same character.
  nibble_hex_converter u_conv (
    .clk      (clk),
    .nibble_i (shift_q[W-1 -: 4]),
    .ascii_o  (conv_char)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_char  = 8'h00;
    in_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SEND_HEX;
      SEND_HEX: begin
        out_valid = 1'b1;
        out_char  = conv_char;
        if (out_ready) begin
          shift_d = shift_q << 4;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = APPEND_NEWLINE ? SEND_CR : IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = FETCH;
          end
        end
      end
      SEND_CR: begin
        out_valid = 1'b1;
        out_char  = CHAR_CR;
        if (out_ready) state_d = SEND_LF;
      end
      SEND_LF: begin
        out_valid = 1'b1;
        out_char  = CHAR_LF;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_hex_word_serializer.sv
// Scoreboarded bench for hex_word_serializer across three parameterizations.
module tb_hex_word_serializer;

  logic clk = 1'b0;
  logic rst;

  logic [15:0]  a_in_data;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]   a_out_char;
  logic [7:0]   b_in_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]   b_out_char;
  logic [127:0] c_in_data;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [7:0]   c_out_char;

  int checks = 0;
  int errors = 0;
  int a_pops = 0;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] c_q[$];

  always #5 clk = ~clk;

  hex_word_serializer #(.DATA_BYTES(2), .APPEND_NEWLINE(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_char(a_out_char), .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy));

  hex_word_serializer #(.DATA_BYTES(1), .APPEND_NEWLINE(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_char(b_out_char), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy));

  hex_word_serializer #(.DATA_BYTES(16), .APPEND_NEWLINE(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_char(c_out_char), .out_valid(c_out_valid), .out_ready(c_out_ready), .busy(c_busy));

  // Scoreboard monitors: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin : mon_a
    logic [7:0] exp_c;
    if (a_out_valid && a_out_ready) begin
      checks++;
      a_pops++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_char: got %h, expected no character", a_out_char);
      end else begin
        exp_c = a_q.pop_front();
        if (a_out_char !== exp_c) begin
          errors++;
          $display("FAIL a_char: got %h, expected %h", a_out_char, exp_c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] exp_c;
    if (b_out_valid && b_out_ready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_char: got %h, expected no character", b_out_char);
      end else begin
        exp_c = b_q.pop_front();
        if (b_out_char !== exp_c) begin
          errors++;
          $display("FAIL b_char: got %h, expected %h", b_out_char, exp_c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [7:0] exp_c;
    if (c_out_valid && c_out_ready) begin
      checks++;
      if (c_q.size() == 0) begin
        errors++;
        $display("FAIL c_char: got %h, expected no character", c_out_char);
      end else begin
        exp_c = c_q.pop_front();
        if (c_out_char !== exp_c) begin
          errors++;
          $display("FAIL c_char: got %h, expected %h", c_out_char, exp_c);
        end
      end
    end
  end

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic valid_of(input int inst);
    case (inst)
      0: return a_out_valid;
      1: return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return a_in_ready;
      1: return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic int qsize_of(input int inst);
    case (inst)
      0: return a_q.size();
      1: return b_q.size();
      default: return c_q.size();
    endcase
  endfunction

  task automatic push_one(input int inst, input logic [7:0] ch);
    case (inst)
      0: a_q.push_back(ch);
      1: b_q.push_back(ch);
      default: c_q.push_back(ch);
    endcase
  endtask

  // Reference model: independent string lookup of each nibble, MS nibble first.
  task automatic push_exp(input int inst, input logic [127:0] w, input int nchars, input bit nl);
    string hd;
    logic [3:0] nib;
    hd = "0123456789ABCDEF";
    for (int i = 0; i < nchars; i++) begin
      nib = w[4*(nchars-1-i) +: 4];
      push_one(inst, hd[nib]);
    end
    if (nl) begin
      push_one(inst, 8'h0D);
      push_one(inst, 8'h0A);
    end
  endtask

  task automatic set_in(input int inst, input logic [127:0] w, input logic v);
    case (inst)
      0: begin a_in_data = w[15:0]; a_in_valid = v; end
      1: begin b_in_data = w[7:0];  b_in_valid = v; end
      default: begin c_in_data = w; c_in_valid = v; end
    endcase
  endtask

  // Presents a word for one cycle; returns #1 after the accepting edge.
  task automatic offer(input int inst, input logic [127:0] w);
    @(posedge clk); #1;
    set_in(inst, w, 1'b1);
    @(negedge clk);
    checks++;
    if (ready_of(inst) !== 1'b1) begin
      errors++;
      $display("FAIL offer_in_ready[%0d]: got %b, expected 1", inst, ready_of(inst));
    end
    @(posedge clk); #1;
    set_in(inst, w, 1'b0);
  endtask

  // Counts busy cycles at falling edges; exits at the first idle falling edge.
  task automatic measure_busy(input int inst, output int n, output int first_valid);
    n = 0;
    first_valid = 0;
    @(negedge clk);
    while (busy_of(inst) && n < 200) begin
      n++;
      if (valid_of(inst) && first_valid == 0) first_valid = n;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout[%0d]: still busy after %0d cycles", inst, n);
    end
  endtask

  task automatic check_drained(input int inst, input string name);
    checks++;
    if (qsize_of(inst) != 0 || ready_of(inst) !== 1'b1) begin
      errors++;
      $display("FAIL %s_drained: pending=%0d in_ready=%b, expected pending=0 in_ready=1",
               name, qsize_of(inst), ready_of(inst));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({a_out_valid, a_out_char, a_busy, a_in_ready, c_out_valid, c_busy, c_in_ready} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b char=%h busy=%b rdy=%b, expected all 0",
               a_out_valid, a_out_char, a_busy, a_in_ready);
    end
    checks++;
    if (u_a.cnt_q !== '0 || u_a.shift_q !== '0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d shift=%h, expected 0 and 0", u_a.cnt_q, u_a.shift_q);
    end
    #21 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 111", {a_in_ready, b_in_ready, c_in_ready});
    end
  endtask

  task automatic test_basic();
    int n, fv;
    a_q.push_back(8'h31); a_q.push_back(8'h41); a_q.push_back(8'h32);
    a_q.push_back(8'h46); a_q.push_back(8'h0D); a_q.push_back(8'h0A);
    offer(0, 128'h1A2F);
    measure_busy(0, n, fv);
    checks++;
    if (fv != 2) begin
      errors++;
      $display("FAIL basic_latency: first out_valid in cycle %0d, expected 2", fv);
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, expected 10", n);
    end
    check_drained(0, "basic");
  endtask

  task automatic test_backpressure();
    int n, fv;
    bit found;
    push_exp(0, 128'h1A2F, 4, 1'b1);
    offer(0, 128'h1A2F);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (a_out_valid && a_out_char == 8'h41) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL bp_find: char 41 not presented within 20 cycles");
    end
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_out_valid, a_out_char, 3'(u_a.cnt_q)} !== {1'b1, 8'h41, 3'd1}) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b char=%h cnt=%0d, expected valid=1 char=41 cnt=1",
                 a_out_valid, a_out_char, u_a.cnt_q);
      end
    end
    a_out_ready = 1'b1;
    measure_busy(0, n, fv);
    check_drained(0, "bp");
  endtask

  task automatic test_back_to_back();
    int n, fv;
    push_exp(0, 128'h1A2F, 4, 1'b1);
    @(posedge clk); #1;
    a_in_data = 16'h1A2F; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_data = 16'hFFFF;
    n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_ready_rise: in_ready rose after %0d cycles, expected 10", n);
    end
    push_exp(0, 128'h00B0, 4, 1'b1);
    a_in_data = 16'h00B0;
    @(posedge clk); #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, expected 1", a_busy);
    end
    a_in_valid = 1'b0;
    measure_busy(0, n, fv);
    check_drained(0, "b2b");
  endtask

  task automatic test_reset_mid_word();
    int n, fv, base;
    bit found;
    push_exp(0, 128'h1A2F, 4, 1'b1);
    base = a_pops;
    offer(0, 128'h1A2F);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (a_pops >= base + 2 && a_out_valid) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rmw_find: third character not presented within 40 cycles");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_out_char, a_busy, a_in_ready} !== 11'b0) begin
      errors++;
      $display("FAIL rmw_async: got valid=%b char=%h busy=%b rdy=%b, expected all 0",
               a_out_valid, a_out_char, a_busy, a_in_ready);
    end
    a_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmw_release_ready: got %b, expected 1", a_in_ready);
    end
    base = a_pops;
    push_exp(0, 128'hC3D4, 4, 1'b1);
    offer(0, 128'hC3D4);
    measure_busy(0, n, fv);
    checks++;
    if (a_pops - base != 6) begin
      errors++;
      $display("FAIL rmw_char_count: got %0d characters, expected 6", a_pops - base);
    end
    check_drained(0, "rmw");
  endtask

  task automatic test_no_newline();
    int n, fv;
    logic [7:0] words [2];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    for (int w = 0; w < 2; w++) begin
      push_exp(1, {120'h0, words[w]}, 2, 1'b0);
      offer(1, {120'h0, words[w]});
      measure_busy(1, n, fv);
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL nonl_busy_cycles: word %h got %0d, expected 4", words[w], n);
      end
      check_drained(1, "nonl");
    end
  endtask

  task automatic test_wide();
    int n, fv;
    push_exp(2, 128'h0123456789ABCDEF0123456789ABCDEF, 32, 1'b1);
    offer(2, 128'h0123456789ABCDEF0123456789ABCDEF);
    measure_busy(2, n, fv);
    checks++;
    if (n != 66 || fv != 2) begin
      errors++;
      $display("FAIL wide_timing: busy=%0d first_valid=%0d, expected 66 and 2", n, fv);
    end
    check_drained(2, "wide");
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_no_newline();
    test_wide();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
